// File: rtl/rst_sequencer_pkg.sv
// rtl/rst_sequencer_pkg.sv - sequencer state encoding and counter width helper
package rst_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_RESET,
      ST_WAIT_LOCK,
      ST_HOLD,
      ST_RELEASE,
      ST_RUN
   } state_e;

   // Bits needed to hold 0..value-1, never fewer than one.
   function automatic int clog2_w(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/rst_sequencer_sync_bit.sv
// rtl/rst_sequencer_sync_bit.sv - STAGES-deep single-bit synchroniser with async active-low clear
module rst_sequencer_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q = chain_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - lock-qualified reset generator releasing NUM_OUT resets in staggered order
module rst_sequencer
   import rst_sequencer_pkg::*;
#(
   parameter int NUM_OUT        = 3,
   parameter int SYNC_STAGES    = 2,
   parameter int LOCK_FILTER    = 16,
   parameter int HOLD_CYCLES    = 8,
   parameter int STAGGER_CYCLES = 4,
   parameter int CNT_W          = 8
) (
   input  logic               clk,
   input  logic               rstn_in,
   input  logic               pll_locked,
   input  logic               bufpll_locked,
   input  logic               sw_rst_req,
   output logic [NUM_OUT-1:0] rst_out,
   output logic               rst_done,
   output logic [CNT_W-1:0]   lock_loss_cnt
);

   localparam int FILT_W    = clog2_w(LOCK_FILTER);
   localparam int HOLD_W    = clog2_w(HOLD_CYCLES);
   localparam int STAG_SPAN = (NUM_OUT - 1) * STAGGER_CYCLES;
   localparam int STAG_W    = clog2_w(STAG_SPAN);

   state_e              state_q, state_d;
   logic [FILT_W-1:0]   filt_q, filt_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [STAG_W-1:0]   stag_q, stag_d;
   logic [NUM_OUT-1:0]  rst_q, rst_d;
   logic                done_q, done_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [31:0]         stag_next;
   logic                rstn_sync;
   logic                lock_raw;
   logic                lock_s;

   rst_sequencer_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rstn (
      .clk   (clk),
      .rst_n (rstn_in),
      .d     (1'b1),
      .q     (rstn_sync)
   );

   // Lock sampling starts only once out of RESET, so the filter sees the full synchroniser latency.
   assign lock_raw = pll_locked & bufpll_locked & (state_q != ST_RESET);

   rst_sequencer_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
      .clk   (clk),
      .rst_n (rstn_in),
      .d     (lock_raw),
      .q     (lock_s)
   );

   always_comb begin
      state_d   = state_q;
      filt_d    = filt_q;
      hold_d    = hold_q;
      stag_d    = stag_q;
      rst_d     = rst_q;
      done_d    = done_q;
      cnt_d     = cnt_q;
      stag_next = 32'(stag_q) + 32'd1;

      case (state_q)
         ST_RESET: begin
            rst_d  = '1;
            done_d = 1'b0;
            if (rstn_sync) state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            rst_d  = '1;
            done_d = 1'b0;
            if (!lock_s) begin
               filt_d = '0;
            end else if (filt_q == FILT_W'(LOCK_FILTER - 1)) begin
               state_d = ST_HOLD;
               hold_d  = '0;
               filt_d  = '0;
            end else begin
               filt_d = filt_q + 1'b1;
            end
         end
         default: begin
            // HOLD, RELEASE and RUN: lock loss outranks a software request.
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
               rst_d   = '1;
               done_d  = 1'b0;
               filt_d  = '0;
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end else if (sw_rst_req) begin
               state_d = ST_HOLD;
               hold_d  = '0;
               rst_d   = '1;
               done_d  = 1'b0;
            end else if (state_q == ST_HOLD) begin
               if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                  rst_d[0] = 1'b0;
                  stag_d   = '0;
                  if (NUM_OUT == 1) begin
                     state_d = ST_RUN;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_RELEASE;
                  end
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end else if (state_q == ST_RELEASE) begin
               for (int k = 1; k < NUM_OUT; k++) begin
                  if (stag_next >= 32'(k * STAGGER_CYCLES)) rst_d[k] = 1'b0;
               end
               if (stag_next >= 32'(STAG_SPAN)) begin
                  state_d = ST_RUN;
                  done_d  = 1'b1;
               end else begin
                  stag_d = stag_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn_in) begin
      if (!rstn_in) begin
         state_q <= ST_RESET;
         filt_q  <= '0;
         hold_q  <= '0;
         stag_q  <= '0;
         rst_q   <= '1;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         filt_q  <= filt_d;
         hold_q  <= hold_d;
         stag_q  <= stag_d;
         rst_q   <= rst_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rst_out       = rst_q;
   assign rst_done      = done_q;
   assign lock_loss_cnt = cnt_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - scoreboard bench for rst_sequencer (default and CNT_W=2 instances)
module tb_rst_sequencer;

   logic       clk;
   logic       rstn_in;
   logic       pll_locked;
   logic       bufpll_locked;
   logic       sw_rst_req;
   logic [2:0] rst_out;
   logic       rst_done;
   logic [7:0] lock_loss_cnt;
   logic [2:0] rst_out_s;
   logic       rst_done_s;
   logic [1:0] lock_loss_cnt_s;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int         cyc;
      logic [2:0] rst;
      logic       done;
      logic [7:0] cnt;
      logic [1:0] cnt_s;
      string      tag;
   } exp_t;

   exp_t exp_q[$];

   rst_sequencer u_dut (
      .clk           (clk),
      .rstn_in       (rstn_in),
      .pll_locked    (pll_locked),
      .bufpll_locked (bufpll_locked),
      .sw_rst_req    (sw_rst_req),
      .rst_out       (rst_out),
      .rst_done      (rst_done),
      .lock_loss_cnt (lock_loss_cnt)
   );

   rst_sequencer #(.CNT_W(2)) u_dut_sat (
      .clk           (clk),
      .rstn_in       (rstn_in),
      .pll_locked    (pll_locked),
      .bufpll_locked (bufpll_locked),
      .sw_rst_req    (sw_rst_req),
      .rst_out       (rst_out_s),
      .rst_done      (rst_done_s),
      .lock_loss_cnt (lock_loss_cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int c, input logic [2:0] r, input logic d,
                       input logic [7:0] n, input logic [1:0] ns, input string tag);
      exp_t e;
      e.cyc = c; e.rst = r; e.done = d; e.cnt = n; e.cnt_s = ns; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic check_reset_now(input string tag);
      checks++;
      if (rst_out !== 3'b111 || rst_done !== 1'b0 || lock_loss_cnt !== 8'd0 ||
          rst_out_s !== 3'b111 || rst_done_s !== 1'b0 || lock_loss_cnt_s !== 2'd0) begin
         errors++;
         $display("FAIL %s: got rst=%b done=%b cnt=%0d rst_s=%b done_s=%b cnt_s=%0d, want rst=111 done=0 cnt=0 cnt_s=0",
                  tag, rst_out, rst_done, lock_loss_cnt, rst_out_s, rst_done_s, lock_loss_cnt_s);
      end
   endtask

   // Monitor: every change of the observed outputs must match the next queued expectation.
   initial begin
      logic [17:0] prev;
      logic [17:0] obs;
      logic [17:0] want;
      exp_t        e;
      prev = {3'b111, 1'b0, 8'd0, 3'b111, 1'b0, 2'd0};
      forever begin
         @(negedge clk);
         obs = {rst_out, rst_done, lock_loss_cnt, rst_out_s, rst_done_s, lock_loss_cnt_s};
         if (obs !== prev) begin
            prev = obs;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change cyc %0d: got rst=%b done=%b cnt=%0d cnt_s=%0d, want no change",
                        cyc, rst_out, rst_done, lock_loss_cnt, lock_loss_cnt_s);
            end else begin
               e = exp_q.pop_front();
               want = {e.rst, e.done, e.cnt, e.rst, e.done, e.cnt_s};
               if (e.cyc != cyc || obs !== want) begin
                  errors++;
                  $display("FAIL %s: got cyc %0d rst=%b done=%b cnt=%0d rst_s=%b done_s=%b cnt_s=%0d, want cyc %0d rst=%b done=%b cnt=%0d cnt_s=%0d",
                           e.tag, cyc, rst_out, rst_done, lock_loss_cnt, rst_out_s, rst_done_s,
                           lock_loss_cnt_s, e.cyc, e.rst, e.done, e.cnt, e.cnt_s);
               end
            end
         end
      end
   end

   initial begin
      int c0, b, s, d, e, f, n;
      rstn_in       = 1'b1;
      pll_locked    = 1'b1;
      bufpll_locked = 1'b1;
      sw_rst_req    = 1'b0;
      #1 rstn_in = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_now("reset_state");

      // Power-up: 2 sync + 2 lock sync + 1 + 16 filter + 8 hold
      c0 = cyc;
      rstn_in = 1'b1;
      push(c0 + 29, 3'b110, 1'b0, 8'd0, 2'd0, "pwr_rel0");
      push(c0 + 33, 3'b100, 1'b0, 8'd0, 2'd0, "pwr_rel1");
      push(c0 + 37, 3'b000, 1'b1, 8'd0, 2'd0, "pwr_run");
      wait_until(c0 + 42);

      // Lock loss in RUN, then a one-cycle pll glitch while re-qualifying
      b = cyc;
      bufpll_locked = 1'b0;
      push(b + 3, 3'b111, 1'b0, 8'd1, 2'd1, "loss_run");
      wait_until(b + 6);
      bufpll_locked = 1'b1;
      wait_until(b + 17);
      pll_locked = 1'b0;
      wait_until(b + 18);
      pll_locked = 1'b1;
      push(b + 44, 3'b110, 1'b0, 8'd1, 2'd1, "glitch_rel0");
      push(b + 48, 3'b100, 1'b0, 8'd1, 2'd1, "glitch_rel1");
      push(b + 52, 3'b000, 1'b1, 8'd1, 2'd1, "glitch_run");
      wait_until(b + 56);

      // Software reset in RUN
      s = cyc;
      sw_rst_req = 1'b1;
      push(s + 1, 3'b111, 1'b0, 8'd1, 2'd1, "sw_assert");
      wait_until(s + 1);
      sw_rst_req = 1'b0;
      push(s + 9, 3'b110, 1'b0, 8'd1, 2'd1, "sw_rel0");
      push(s + 13, 3'b100, 1'b0, 8'd1, 2'd1, "sw_rel1");
      push(s + 17, 3'b000, 1'b1, 8'd1, 2'd1, "sw_run");
      wait_until(s + 20);

      // Software request coincident with lock loss
      d = cyc;
      pll_locked = 1'b0;
      wait_until(d + 2);
      sw_rst_req = 1'b1;
      push(d + 3, 3'b111, 1'b0, 8'd2, 2'd2, "sw_and_loss");
      wait_until(d + 3);
      sw_rst_req = 1'b0;
      wait_until(d + 5);
      pll_locked = 1'b1;
      push(d + 31, 3'b110, 1'b0, 8'd2, 2'd2, "coinc_rel0");
      push(d + 35, 3'b100, 1'b0, 8'd2, 2'd2, "coinc_rel1");
      push(d + 39, 3'b000, 1'b1, 8'd2, 2'd2, "coinc_run");
      wait_until(d + 42);

      // Three more losses (first in RUN, then in HOLD): default counts 5, CNT_W=2 saturates at 3
      n = 2;
      f = 0;
      for (int i = 0; i < 3; i++) begin
         e = cyc;
         f = e;
         pll_locked = 1'b0;
         n++;
         push(e + 3, 3'b111, 1'b0, 8'(n), (n > 3) ? 2'd3 : 2'(n), "sat_loss");
         wait_until(e + 5);
         pll_locked = 1'b1;
         wait_until(e + 25);
      end

      // rstn_in asserted after rst_out[0] released
      push(f + 31, 3'b110, 1'b0, 8'd5, 2'd3, "final_rel0");
      wait_until(f + 32);
      #2 rstn_in = 1'b0;
      #1 check_reset_now("async_reset");
      push(f + 33, 3'b111, 1'b0, 8'd0, 2'd0, "async_reset_seen");
      wait_until(f + 40);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_events: got %0d unmatched, want 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
